// File: rtl/cplx_acc.sv
// cplx_acc: complex frame accumulator with valid/ready in/out ports.
// Define CPLX_ACC_SAT_EN to make each component add saturate instead of wrap.
module cplx_acc #(
  parameter int DW    = 16,
  parameter int CNT_W = 8,
  parameter int ACC_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*DW-1:0]    in_data,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_re,
  output logic [ACC_W-1:0]   out_im
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_len, r_cnt;
  logic [ACC_W-1:0] r_re, r_im;
  logic w_acc, w_start, w_last;
  logic signed [DW-1:0] w_in_re, w_in_im;
  function automatic logic [ACC_W-1:0] add_c(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
`ifdef CPLX_ACC_SAT_EN
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    return (s[ACC_W] ^ s[ACC_W-1]) ? {s[ACC_W], {(ACC_W-1){~s[ACC_W]}}} : s[ACC_W-1:0];
`else
    return a + b;
`endif
  endfunction
  assign w_in_re   = in_data[2*DW-1:DW];
  assign w_in_im   = in_data[DW-1:0];
  assign in_ready  = r_state == ACC;
  assign out_valid = r_state == HOLD;
  assign busy      = r_state != IDLE;
  assign out_re    = r_re;
  assign out_im    = r_im;
  assign w_acc     = in_valid && in_ready;
  assign w_start   = start && r_state == IDLE;
  assign w_last    = r_cnt == r_len - CNT_W'(1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? (len == '0 ? HOLD : ACC) : IDLE;
      ACC:     w_next = (w_acc && w_last) ? HOLD : ACC;
      HOLD:    w_next = out_ready ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_re    <= '0;
      r_im    <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_len <= len;
        r_cnt <= '0;
        r_re  <= '0;
        r_im  <= '0;
      end else if (w_acc) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_re  <= add_c(r_re, ACC_W'(w_in_re));
        r_im  <= add_c(r_im, ACC_W'(w_in_im));
      end
    end
  end
endmodule

// File: tb/tb_cplx_acc.sv
// tb_cplx_acc: randomized scoreboard bench for cplx_acc (ACC_W=18 to reach overflow).
module tb_cplx_acc;
  localparam int DW = 16, CNT_W = 8, AW = 18;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [CNT_W-1:0] len = '0;
  logic [2*DW-1:0] in_data = '0;
  logic in_ready, busy, out_valid;
  logic [AW-1:0] out_re, out_im;
  typedef struct {longint re; longint im;} sum_t;
  sum_t exp_q[$];
  logic [31:0] smp [256];
  int tests = 0, fails = 0;

  cplx_acc #(.DW(DW), .CNT_W(CNT_W), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_re(out_re), .out_im(out_im));

  always #5 clk = ~clk;

  function automatic longint sx(input logic [AW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint step(input longint a, input longint b);
    longint s, h;
    s = a + b;
    h = longint'(1) <<< (AW - 1);
`ifdef CPLX_ACC_SAT_EN
    return s > h - 1 ? h - 1 : (s < -h ? -h : s);
`else
    return ((s + h) % (2 * h) + 2 * h) % (2 * h) - h;
`endif
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        sum_t e;
        e = exp_q.pop_front();
        chk("out_re", sx(out_re), e.re);
        chk("out_im", sx(out_im), e.im);
      end
    end
  end

  task automatic pulse_start(input int n);
    start = 1;
    len = CNT_W'(n);
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic frame(input int n, input int gaps, input int stall);
    longint er = 0, ei = 0, sr, si;
    for (int i = 0; i < n; i++) begin
      er = step(er, longint'($signed(smp[i][31:16])));
      ei = step(ei, longint'($signed(smp[i][15:0])));
    end
    exp_q.push_back('{er, ei});
    pulse_start(n);
    if (n == 0) chk("len0_in_ready", in_ready, 0);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gaps)) begin
        start = 1;
        len = 8'd3;
        @(posedge clk); #1;
        start = 0;
      end
      in_valid = 1;
      in_data = smp[i];
      chk("in_ready_acc", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 0;
      in_data = $urandom;
    end
    chk("out_valid_latency", out_valid, 1);
    chk("in_ready_drop", in_ready, 0);
    chk("busy_hold", busy, 1);
    sr = sx(out_re);
    si = sx(out_im);
    repeat (stall) begin
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_re", sx(out_re), sr);
      chk("stall_im", sx(out_im), si);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("out_valid_drop", out_valid, 0);
    chk("busy_idle", busy, 0);
    chk("keep_re", sx(out_re), sr);
  endtask

  initial begin
    #2;
    chk("rst_state", {in_ready, out_valid, busy}, 0);
    chk("rst_re", out_re, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    smp[0] = 32'h0006_0002; smp[1] = 32'h0002_0000;
    frame(2, 0, 0);
    chk("basic_re", sx(out_re), 8);
    chk("basic_im", sx(out_im), 2);
    for (int i = 0; i < 3; i++) smp[i] = 32'hFFFF_0001;
    frame(3, 0, 1);
    chk("neg_re", sx(out_re), -3);
    chk("neg_im", sx(out_im), 3);
    for (int i = 0; i < 4; i++) smp[i] = $urandom;
    frame(4, 3, 5);
    frame(0, 0, 2);
    chk("len0_re", sx(out_re), 0);
    chk("len0_im", sx(out_im), 0);
    for (int i = 0; i < 5; i++) smp[i] = 32'h7FFF_8000;
    frame(5, 1, 0);
`ifdef CPLX_ACC_SAT_EN
    chk("ovf_re", sx(out_re), 131071);
    chk("ovf_im", sx(out_im), -131072);
`else
    chk("ovf_re", sx(out_re), -98309);
    chk("ovf_im", sx(out_im), 98304);
`endif
    pulse_start(4);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1;
      in_data = 32'h0005_0003;
      @(posedge clk); #1;
    end
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("arst_flags", {in_ready, out_valid, busy}, 0);
    chk("arst_re", out_re, 0);
    chk("arst_im", out_im, 0);
    @(posedge clk); #1;
    rst = 0;
    smp[0] = 32'h0001_0001;
    frame(1, 0, 0);
    chk("post_rst_re", sx(out_re), 1);
    chk("post_rst_im", sx(out_im), 1);
    for (int f = 0; f < 20; f++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) smp[i] = $urandom;
      frame(n, 2, $urandom_range(0, 3));
    end
    for (int i = 0; i < 255; i++) smp[i] = $urandom;
    frame(255, 0, 1);
    @(posedge clk); #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cplx_acc.md
Name: cplx_acc

Overview:
- Frame accumulator sitting directly downstream of the complex add/sub stage.
- Consumes its packed 32-bit result stream ({re[15:0], im[15:0]}, signed two's complement) under a valid/ready handshake.
- Sums a programmable number of samples per frame and presents the complex sum on a valid/ready output port.
- Used for averaging/integration of add/sub results before readout.

Parameters:
- DW, 16, width of each signed input component (re, im).
- CNT_W, 8, width of the frame-length field and sample counter.
- ACC_W, 24, width of each signed accumulator/output component (ACC_W >= DW).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  1-cycle pulse; begins a frame; sampled only in IDLE.
- len  input  CNT_W  samples per frame; latched on accepted start.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  2*DW  {re, im}; re = [2*DW-1:DW], im = [DW-1:0], signed.
- busy  output  1  high in ACC and HOLD.
- out_valid  output  1  sum available.
- out_ready  input  1  downstream takes sum.
- out_re  output  ACC_W  signed real sum.
- out_im  output  ACC_W  signed imaginary sum.

Behaviour:
- Reset (async, any state, including mid-frame):
  - State = IDLE; accumulators, counter and len register = 0.
  - in_ready, out_valid, busy = 0; out_re = out_im = 0.
- FSM states: IDLE, ACC, HOLD.
- IDLE:
  - start=1 latches len, clears accumulators and counter.
  - len != 0: go to ACC.
  - len == 0: go directly to HOLD with zero sums.
  - start while busy is ignored.
- ACC:
  - in_ready = 1 (combinational from state only, no dependence on in_valid).
  - Sample accepted when in_valid && in_ready.
  - Each accepted sample sign-extends re/im to ACC_W and adds it to its accumulator.
  - Counter increments per accepted sample.
  - in_valid=0 cycles stall without change.
  - Accept of sample number len (counter == len-1): go to HOLD; in_ready drops the next cycle.
- HOLD:
  - out_valid = 1; out_re/out_im driven from the accumulator registers and held stable while out_valid && !out_ready.
  - out_valid && out_ready: go to IDLE; out_valid = 0 next cycle.
  - out_re/out_im keep the last sum until the next start.
- Latency: out_valid rises the cycle after the last sample is accepted. A new start is accepted no earlier than the cycle after the handshake; minimum 1 IDLE cycle between frames.
- Arithmetic: signed two's complement; default wraps modulo 2^ACC_W (see Optional Feature).
- With defaults (255 x 32767 < 2^23) overflow cannot occur.
- busy = (state != IDLE).

Optional Feature:
- Macro CPLX_ACC_SAT_EN.
- Defined:
  - Each component add saturates independently to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Once saturated, further samples that would move the value further out of range leave it pinned.
  - Samples of the opposite sign move it back in range normally.
- Undefined: plain wrap-around addition. No port differences either way.

Test Plan:
- Basic frame: len=2; samples 0x0006_0002, 0x0002_0000 -> out_valid 1 cycle after 2nd accept; out_re=8, out_im=2.
- Negative/sign-extension: len=3; 3 x 0xFFFF_0001 -> out_re=0xFFFFFD (-3), out_im=3.
- Handshake stalls: len=4 with in_valid gaps, and out_ready held 0 for 5 cycles in HOLD -> sums unaffected by gaps; out_re/out_im/out_valid stable until out_ready=1; start pulsed mid-frame is ignored.
- len=0 -> out_valid next cycle; out_re=out_im=0; in_ready never asserted.
- Overflow with ACC_W=18: len=5; 5 x 0x7FFF_8000 ->
  - without CPLX_ACC_SAT_EN: out_re=-98309, out_im=-163840 wrapped = 98304.
  - with CPLX_ACC_SAT_EN: out_re=131071, out_im=-131072.
- Reset mid-frame: assert rst after 2 of len=4 samples -> all outputs 0 immediately (async); next frame len=1 with 0x0001_0001 gives out_re=out_im=1.
